// File: rtl/led_fade_sequencer_if.sv
// Control/config/brightness bundle between the fade sequencer and its host.
// The host drives keyframe writes and start/stop; the sequencer returns brightness and status.
interface led_fade_sequencer_if #(
    parameter int unsigned NUM_KEYS = 4
) ();
    localparam int unsigned KW = $clog2(NUM_KEYS);

    logic          cfg_we;
    logic [KW-1:0] cfg_addr;
    logic [23:0]   cfg_data;
    logic          start;
    logic          stop;
    logic [7:0]    bright_r;
    logic [7:0]    bright_g;
    logic [7:0]    bright_b;
    logic [KW-1:0] key_idx;
    logic          busy;
    logic          loop_done;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, stop,
        input  bright_r, bright_g, bright_b, key_idx, busy, loop_done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, stop,
        output bright_r, bright_g, bright_b, key_idx, busy, loop_done
    );
endinterface

// File: rtl/led_fade_sequencer.sv
// RGB keyframe fade sequencer feeding three 8-bit pwm brightness inputs.
// Optional LED_FADE_GAMMA_EN adds a registered (lin*lin)>>8 output stage.
module led_fade_sequencer #(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned PRESCALE   = 48000,
    parameter int unsigned HOLD_TICKS = 500
) (
    input  logic                  clk,
    input  logic                  reset_n,
    led_fade_sequencer_if.slave   bus
);
    localparam int unsigned KW = $clog2(NUM_KEYS);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, FADE, HOLD} state_e;

    state_e        state_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [HW-1:0] hold_q;
    logic [KW-1:0] key_q;
    logic          busy_q;
    logic          loop_done_q;
    logic [7:0]    lin_q [3];
    logic [23:0]   table_q [NUM_KEYS];

    logic [23:0]   tgt_c;
    logic [7:0]    tgt_ch_c [3];
    logic          tick_c;
    logic          arrived_c;

    // One linear step toward the target, never overshooting it.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)      return cur + 8'd1;
        else if (cur > tgt) return cur - 8'd1;
        else                return cur;
    endfunction

    always_comb begin
        tgt_c       = table_q[key_q];
        tgt_ch_c[0] = tgt_c[23:16];
        tgt_ch_c[1] = tgt_c[15:8];
        tgt_ch_c[2] = tgt_c[7:0];
        tick_c      = busy_q && (presc_q == PW'(PRESCALE - 1));
        presc_d     = tick_c ? '0 : presc_q + PW'(1);
        arrived_c   = (lin_q[0] == tgt_ch_c[0]) && (lin_q[1] == tgt_ch_c[1]) &&
                      (lin_q[2] == tgt_ch_c[2]);
    end

    // Sequencer state, keyframe table and linear brightness registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            hold_q      <= '0;
            key_q       <= '0;
            busy_q      <= 1'b0;
            loop_done_q <= 1'b0;
            for (int i = 0; i < 3; i++) lin_q[i] <= 8'd0;
            for (int k = 0; k < int'(NUM_KEYS); k++) table_q[k] <= 24'd0;
        end else begin
            loop_done_q <= 1'b0;
            if (bus.cfg_we) table_q[bus.cfg_addr] <= bus.cfg_data;

            if (bus.stop) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                presc_q <= '0;
            end else if (bus.start) begin
                // Restart from the current brightness; no jump to key 0's colour.
                state_q <= FADE;
                busy_q  <= 1'b1;
                key_q   <= '0;
                presc_q <= '0;
                hold_q  <= '0;
            end else begin
                if (busy_q) presc_q <= presc_d;
                if (tick_c) begin
                    case (state_q)
                        FADE: begin
                            if (arrived_c) begin
                                state_q <= HOLD;
                                hold_q  <= '0;
                            end else begin
                                for (int i = 0; i < 3; i++)
                                    lin_q[i] <= step_toward(lin_q[i], tgt_ch_c[i]);
                            end
                        end
                        HOLD: begin
                            if (hold_q == HW'(HOLD_TICKS - 1)) begin
                                state_q <= FADE;
                                hold_q  <= '0;
                                if (key_q == KW'(NUM_KEYS - 1)) begin
                                    key_q       <= '0;
                                    loop_done_q <= 1'b1;
                                end else begin
                                    key_q <= key_q + KW'(1);
                                end
                            end else begin
                                hold_q <= hold_q + HW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [7:0]  gam_q [3];
    logic [15:0] sq_c  [3];

    always_comb begin
        for (int i = 0; i < 3; i++) sq_c[i] = 16'(lin_q[i]) * 16'(lin_q[i]);
    end

    // Square-law gamma stage, one clock behind the linear value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) gam_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 3; i++) gam_q[i] <= sq_c[i][15:8];
        end
    end

    assign bus.bright_r = gam_q[0];
    assign bus.bright_g = gam_q[1];
    assign bus.bright_b = gam_q[2];
`else
    assign bus.bright_r = lin_q[0];
    assign bus.bright_g = lin_q[1];
    assign bus.bright_b = lin_q[2];
`endif

    assign bus.key_idx   = key_q;
    assign bus.busy      = busy_q;
    assign bus.loop_done = loop_done_q;
endmodule

// File: tb/tb_led_fade_sequencer.sv
// Self-checking bench for led_fade_sequencer (PRESCALE=4, HOLD_TICKS=2, NUM_KEYS=4).
// Expected states are queued when stimulus is applied and popped when sampled.
module tb_led_fade_sequencer;
    localparam int unsigned NK = 4;
    localparam int unsigned PS = 4;
    localparam int unsigned HT = 2;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    led_fade_sequencer_if #(.NUM_KEYS(NK)) bus ();

    led_fade_sequencer #(.NUM_KEYS(NK), .PRESCALE(PS), .HOLD_TICKS(HT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        start;
        logic        stop;
        logic        we;
        logic [1:0]  addr;
        logic [23:0] data;
        int          wait_cyc;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [1:0]  key;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [1:0] key;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    vec_t tv[13];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected pwm value for a given linear brightness.
    function automatic logic [7:0] gm(input logic [7:0] x);
`ifdef LED_FADE_GAMMA_EN
        logic [15:0] p;
        p = 16'(x) * 16'(x);
        return p[15:8];
`else
        return x;
`endif
    endfunction

    task automatic cmp(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_pop(input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            cmp({nm, ".key"},  bus.key_idx, e.key);
            cmp({nm, ".busy"}, bus.busy,    e.busy);
`ifdef LED_FADE_GAMMA_EN
            fork
                begin
                    @(posedge clk);
                    #1;
                    cmp({nm, ".r"}, bus.bright_r, gm(e.r));
                    cmp({nm, ".g"}, bus.bright_g, gm(e.g));
                    cmp({nm, ".b"}, bus.bright_b, gm(e.b));
                end
            join_none
`else
            cmp({nm, ".r"}, bus.bright_r, gm(e.r));
            cmp({nm, ".g"}, bus.bright_g, gm(e.g));
            cmp({nm, ".b"}, bus.bright_b, gm(e.b));
`endif
        end
    endtask

    // Drive one record for a single edge, queue its expectation, sample after wait_cyc edges.
    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        bus.start    = v.start;
        bus.stop     = v.stop;
        bus.cfg_we   = v.we;
        bus.cfg_addr = v.addr;
        bus.cfg_data = v.data;
        e.r = v.r; e.g = v.g; e.b = v.b; e.key = v.key; e.busy = v.busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.cfg_we = 1'b0;
        step(v.wait_cyc - 1);
        check_pop(nm);
    endtask

    task automatic seq(input logic st, input logic sp, input logic we, input logic [1:0] a,
                       input logic [23:0] d, input int w, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b, input logic [1:0] k,
                       input logic bz, input string nm);
        vec_t v;
        v = '{st, sp, we, a, d, w, r, g, b, k, bz};
        apply(v, nm);
    endtask

    initial begin
        int pulses;
        int kexp;

        // start, stop, we, addr, data, wait, r, g, b, key, busy
        tv[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 24'hFF0000, 1,   8'd0,   8'd0,   8'd0,   2'd0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 24'h0,      1,   8'd0,   8'd0,   8'd0,   2'd0, 1'b1};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,      4,   8'd1,   8'd0,   8'd0,   2'd0, 1'b1};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,      396, 8'd100, 8'd0,   8'd0,   2'd0, 1'b1};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,      620, 8'd255, 8'd0,   8'd0,   2'd0, 1'b1};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,      4,   8'd255, 8'd0,   8'd0,   2'd0, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 24'h00FF80, 2,   8'd255, 8'd0,   8'd0,   2'd0, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,      5,   8'd255, 8'd0,   8'd0,   2'd0, 1'b1};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,      1,   8'd255, 8'd0,   8'd0,   2'd1, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,      4,   8'd254, 8'd1,   8'd1,   2'd1, 1'b1};
        tv[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,      508, 8'd127, 8'd128, 8'd128, 2'd1, 1'b1};
        tv[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,      40,  8'd117, 8'd138, 8'd128, 2'd1, 1'b1};
        tv[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,      468, 8'd0,   8'd255, 8'd128, 2'd1, 1'b1};

        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        step(3);
        cmp("rst.r", bus.bright_r, 0);
        cmp("rst.busy", bus.busy, 0);
        cmp("rst.key", bus.key_idx, 0);
        cmp("rst.loop_done", bus.loop_done, 0);
        reset_n = 1'b1;
        step(2);

        // Fade up to red, then mixed fade toward key 1
        for (int i = 0; i < 13; i++) apply(tv[i], $sformatf("vec%0d", i));
        step(2);

        // Asynchronous reset in the middle of a fade
        #3;
        reset_n = 1'b0;
        #1;
        cmp("async_rst.r", bus.bright_r, 0);
        cmp("async_rst.g", bus.bright_g, 0);
        cmp("async_rst.b", bus.bright_b, 0);
        cmp("async_rst.key", bus.key_idx, 0);
        cmp("async_rst.busy", bus.busy, 0);
        step(2);
        reset_n = 1'b1;
        step(1);

        // Cleared table: every key is already at target, 12 ticks per loop
        seq(1'b1, 1'b0, 1'b0, 2'd0, 24'h0, 1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1, "wrap_start");
        pulses = 0;
        for (int c = 1; c <= 100; c++) begin
            step(1);
            kexp = (c / 12) % 4;
            cmp($sformatf("wrap.key@%0d", c), bus.key_idx, kexp);
            cmp($sformatf("wrap.loop_done@%0d", c), bus.loop_done,
                ((c % 48) == 0) ? 1 : 0);
            if (bus.loop_done) pulses++;
        end
        cmp("wrap.pulse_count", pulses, 2);
        seq(1'b0, 1'b1, 1'b0, 2'd0, 24'h0, 1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, "wrap_stop");

        // start/stop collision freezes; later start resumes from frozen value at key 0
        seq(1'b0, 1'b0, 1'b1, 2'd1, 24'hFF0000, 1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, "col_wr");
        seq(1'b1, 1'b0, 1'b0, 2'd0, 24'h0, 1,  8'd0,  8'd0, 8'd0, 2'd0, 1'b1, "col_start");
        seq(1'b0, 1'b0, 1'b0, 2'd0, 24'h0, 12, 8'd0,  8'd0, 8'd0, 2'd1, 1'b1, "col_key1");
        seq(1'b0, 1'b0, 1'b0, 2'd0, 24'h0, 40, 8'd10, 8'd0, 8'd0, 2'd1, 1'b1, "col_ramp");
        seq(1'b1, 1'b1, 1'b0, 2'd0, 24'h0, 1,  8'd10, 8'd0, 8'd0, 2'd1, 1'b0, "col_both");
        seq(1'b0, 1'b0, 1'b0, 2'd0, 24'h0, 20, 8'd10, 8'd0, 8'd0, 2'd1, 1'b0, "col_frozen");
        seq(1'b1, 1'b0, 1'b0, 2'd0, 24'h0, 1,  8'd10, 8'd0, 8'd0, 2'd0, 1'b1, "col_restart");
        seq(1'b0, 1'b0, 1'b0, 2'd0, 24'h0, 4,  8'd9,  8'd0, 8'd0, 2'd0, 1'b1, "col_down1");
        seq(1'b0, 1'b0, 1'b0, 2'd0, 24'h0, 36, 8'd0,  8'd0, 8'd0, 2'd0, 1'b1, "col_down10");
        seq(1'b0, 1'b0, 1'b0, 2'd0, 24'h0, 8,  8'd0,  8'd0, 8'd0, 2'd0, 1'b1, "col_hold");

        step(3);
        cmp("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
